// File: rtl/dram_stream_ctrl.sv
// Host-side DRAM port: LOAD streams bytes into DRAM from address 0, DUMP streams a region back out.
// All outputs are registered except s_ready; one byte per 3 cycles on DUMP without backpressure.
module dram_stream_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int LOAD_LEN  = 65536,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              load_done,
  output logic              dump_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RD, S_WAIT, S_OUT} state_t;

  // Index is one bit wider than the address so a full 2^ADDR_W transfer can terminate.
  localparam logic [ADDR_W:0]   LOAD_LAST = (ADDR_W+1)'(LOAD_LEN - 1);
  localparam logic [ADDR_W:0]   DUMP_LAST = (ADDR_W+1)'(DUMP_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(DUMP_BASE);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d, idx_inc;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                busy_q, busy_d;
  logic                load_done_q, load_done_d;
  logic                dump_done_q, dump_done_d;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_addr_d  = mem_addr_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_din_d   = mem_din_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    load_done_d = 1'b0;
    dump_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end else if (start_dump) begin
          // Read strobe is registered, so it is raised on the way into RD.
          state_d    = S_RD;
          idx_d      = '0;
          mem_read_d = 1'b1;
          mem_addr_d = BASE;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          mem_write_d = 1'b1;
          mem_din_d   = s_data;
          mem_addr_d  = idx_q[ADDR_W-1:0];
          idx_d       = idx_inc;
          if (idx_q == LOAD_LAST) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d     = S_IDLE;
        load_done_d = 1'b1;
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        m_data_d  = mem_dout;
        m_valid_d = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          idx_d     = idx_inc;
          if (idx_q == DUMP_LAST) begin
            state_d     = S_IDLE;
            dump_done_d = 1'b1;
          end else begin
            state_d    = S_RD;
            mem_read_d = 1'b1;
            mem_addr_d = BASE + idx_inc[ADDR_W-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_din_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      mem_din_q   <= mem_din_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign s_ready   = (state_q == S_LOAD);
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign mem_din   = mem_din_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign dump_done = dump_done_q;

endmodule

// File: tb/tb_dram_stream_ctrl.sv
// Scoreboarded bench for dram_stream_ctrl: random LOAD/DUMP traffic against a byte-array memory model.
module tb_dram_stream_ctrl;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int LLEN  = 200;
  localparam int DBASE = 32'hFFFE;
  localparam int DLEN  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_load = 1'b0, start_dump = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, m_valid, m_ready = 1'b1;
  logic [DW-1:0] m_data, mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_write, mem_read, busy, load_done, dump_done;

  dram_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LOAD_LEN(LLEN), .DUMP_BASE(DBASE), .DUMP_LEN(DLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_dump(start_dump),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .load_done(load_done), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_wr[$];
  int  exp_rd[$];
  int  exp_out[$];
  wr_t cur_wr;

  logic [DW-1:0] dram    [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  int load_done_seen = 0;
  int dump_done_seen = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int rd_cyc = 0;
  logic prev_mv = 0, prev_mr = 0, prev_mw = 0, prev_acc = 0;
  logic [DW-1:0] prev_md = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory behind the port: write commits on the edge, read data registered one cycle later.
  initial begin
    for (int i = 0; i < 65536; i++) begin
      dram[i]    = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    forever begin
      @(posedge clk);
      if (mem_write) dram[mem_addr] = mem_din;
      if (mem_read)  mem_dout <= dram[mem_addr];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: compares every bus event against the queued expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mv = 0; prev_mr = 0; prev_mw = 0; prev_acc = 0;
    end else begin
      cyc++;
      if (mem_write && mem_read) chk("rw_overlap", 1, 0);
      if (s_ready) chk("busy_in_load", busy, 1);
      if (mem_write) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          cur_wr = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), cur_wr.addr);
          chk("wr_data", 32'(mem_din), cur_wr.data);
        end
      end
      if (mem_read) begin
        rd_cyc = cyc;
        if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
        else chk("rd_addr", 32'(mem_addr), exp_rd.pop_front());
      end
      if (m_valid && !prev_mv) chk("rd_to_valid_latency", cyc - rd_cyc, 2);
      if (prev_mv && !prev_mr) begin
        chk("stall_hold_valid", m_valid, 1);
        chk("stall_hold_data", m_data, prev_md);
      end
      if (m_valid && m_ready) begin
        if (exp_out.size() == 0) chk("unexpected_out", 1, 0);
        else chk("out_data", 32'(m_data), exp_out.pop_front());
      end
      if (load_done) begin
        load_done_seen++;
        chk("load_done_busy", busy, 0);
        chk("load_done_after_last_write", prev_mw, 1);
      end
      if (dump_done) begin
        dump_done_seen++;
        chk("dump_done_busy", busy, 0);
        chk("dump_done_after_accept", prev_acc, 1);
      end
      prev_mv  = m_valid;
      prev_mr  = m_ready;
      prev_md  = m_data;
      prev_mw  = mem_write;
      prev_acc = m_valid && m_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic ld, input logic dp);
    start_load = ld;
    start_dump = dp;
    tick();
    start_load = 1'b0;
    start_dump = 1'b0;
  endtask

  // Sends n bytes with random gaps; optionally pokes start_dump mid-stream, which must be ignored.
  task automatic load_bytes(input int n, input int gap_max, input bit poke_dump);
    logic [DW-1:0] b;
    logic [DW-1:0] bytes[$];
    int budget;
    for (int i = 0; i < n; i++) begin
      b = DW'($urandom);
      bytes.push_back(b);
      exp_wr.push_back('{addr: i, data: int'(b)});
    end
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        tick();
      end
      start_dump = poke_dump && (i == 10);
      s_valid = 1'b1;
      s_data  = bytes[i];
      budget  = 50;
      do begin
        @(negedge clk);
        budget--;
      end while (!s_ready && budget > 0);
      if (!s_ready) begin
        chk("s_ready_timeout", 0, 1);
        break;
      end
      tick();
      ref_mem[i] = bytes[i];
      start_dump = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_load(input int target);
    int budget = 2000;
    while (load_done_seen < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("load_done_count", load_done_seen, target);
    chk("writes_drained", exp_wr.size(), 0);
    tick();
    chk("idle_after_load", busy, 0);
  endtask

  task automatic run_dump(input int mode, input int target);
    int budget = 2000;
    int a;
    rdy_mode = mode;
    for (int i = 0; i < DLEN; i++) begin
      a = (DBASE + i) % 65536;
      exp_rd.push_back(a);
      exp_out.push_back(int'(ref_mem[a]));
    end
    pulse_start(1'b0, 1'b1);
    while (dump_done_seen < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("dump_done_count", dump_done_seen, target);
    chk("reads_drained", exp_rd.size(), 0);
    chk("outputs_drained", exp_out.size(), 0);
    tick();
    chk("idle_after_dump", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_din"}, mem_din, 0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_dump_done"}, dump_done, 0);
  endtask

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Back-to-back load, then a gapped load started together with a dump request.
    pulse_start(1'b1, 1'b0);
    load_bytes(LLEN, 0, 1'b0);
    wait_load(1);
    pulse_start(1'b1, 1'b1);
    load_bytes(LLEN, 2, 1'b1);
    wait_load(2);

    // Wrapping dump, first without backpressure, then with random stalls.
    run_dump(0, 1);
    run_dump(1, 2);

    // Abort a load after 100 bytes; nothing further may be written or reported.
    pulse_start(1'b1, 1'b0);
    load_bytes(100, 1, 1'b0);
    repeat (3) tick();
    chk("abort_still_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (4) tick();
    chk("abort_no_load_done", load_done_seen, 2);
    chk("abort_writes_drained", exp_wr.size(), 0);
    rst_n = 1'b1;
    tick();

    pulse_start(1'b1, 1'b0);
    load_bytes(LLEN, 1, 1'b0);
    wait_load(3);
    run_dump(1, 3);

    repeat (5) tick();
    chk("final_load_done_count", load_done_seen, 3);
    chk("final_dump_done_count", dump_done_seen, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
